mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS32 datapath. Decodes the opcode held in the instruction register and sequences PC, memory, IR, ALU, register-file and write-data-select strobes across FETCH/DECODE/EXECUTE/MEM/WB states. Stalls on a variable-latency memory handshake. Drives the 32-bit write-data mux select that chooses between the ALU/memory result and the zero-low, 16-bit-upper `lui` immediate.

---
 rtl/mips_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// mips_multicycle_ctrl
// ----------------------------------------------------------------------------
// Main control FSM for the multicycle MIPS32 datapath. Decodes the opcode in
// the instruction register and sequences the PC, memory, IR, ALU, register
// file and write-data-select strobes through FETCH / DECODE / EXECUTE / MEM /
// WB states. It stalls on a variable-latency memory handshake.
//
// Parameters:
//   OPC_W  opcode field width (default 6)
//   CNT_W  retired-instruction counter width (default 32)
//
// Ports:
//   clk            in   rising-edge system clock
//   reset          in   synchronous, active-high reset
//   opcode         in   IR[31:26]
//   mem_ready      in   memory access completes this cycle
//   pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write
//                  out  datapath strobes
//   iord, reg_dst, mem_to_reg, alu_src_a, wd_sel
//                  out  mux selects (wd_sel=1 picks the lui immediate)
//   alu_src_b, alu_op, pc_source
//                  out  2-bit mux / ALU selects
//   state          out  current state, for debug
//   retired        out  count of completed instructions (wraps)
//   illegal_op     out  sticky illegal-opcode flag
//
// Build option:
//   MC_CTRL_ILLEGAL_TRAP_EN  when defined, an unsupported opcode traps into a
//                            terminal TRAP state and sets illegal_op. When
//                            undefined, it retires as a NOP and illegal_op
//                            is tied low.
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int OPC_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic             wd_sel,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_op
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_I_EXEC    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;
  localparam logic [3:0] S_LUI_WB    = 4'd12;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP      = 4'd13;
`endif

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'h00);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'h23);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'h2B);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'h04);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'h08);
  localparam logic [OPC_W-1:0] OP_LUI   = OPC_W'(6'h0F);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'h02);

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       retire_now;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       trap_now;
  logic       illegal_q;
`endif

  // Next-state logic. retire_now marks the edge that leaves a terminal
  // state, which is exactly when an instruction is considered complete.
  always_comb begin
    next_state = state_q;
    retire_now = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    trap_now   = 1'b0;
`endif
    case (state_q)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = S_R_EXEC;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          OP_ADDI:       next_state = S_I_EXEC;
          OP_LUI:        next_state = S_LUI_WB;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            next_state = S_TRAP;
            trap_now   = 1'b1;
`else
            // Unsupported opcode behaves as a NOP and still counts.
            next_state = S_FETCH;
            retire_now = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB: begin
        next_state = S_FETCH;
        retire_now = 1'b1;
      end
      S_MEM_WRITE: begin
        next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
        retire_now = mem_ready;
      end
      S_R_EXEC:   next_state = S_R_WB;
      S_I_EXEC:   next_state = S_I_WB;
      S_R_WB, S_BRANCH, S_JUMP, S_I_WB, S_LUI_WB: begin
        next_state = S_FETCH;
        retire_now = 1'b1;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     next_state = S_TRAP;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter. A reset mid-instruction
  // simply drops the instruction, so nothing is counted on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= next_state;
      if (retire_now) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  // Sticky flag, only cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (trap_now) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign state = state_q;

  // Moore output decode. Only the FETCH IR/PC writes look at mem_ready, so
  // the IR is loaded exactly once per fetched word. Reset overrides every
  // write strobe so an aborted instruction leaves no side effects.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    wd_sel        = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_I_WB:     reg_write = 1'b1;
      S_LUI_WB: begin
        reg_write = 1'b1;
        wd_sel    = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// tb_mips_multicycle_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for mips_multicycle_ctrl. A table of per-cycle vectors
// covers the back-to-back instruction mix, hand-written sequences cover the
// stall, illegal-opcode and mid-instruction reset cases, and a randomized run
// is checked against an instruction-level model (per-opcode state traces with
// stall points). A second, narrow-counter instance checks counter wrap.
// ============================================================================
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic        iord, reg_dst, mem_to_reg, alu_src_a, wd_sel;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        illegal_op;

  // Narrow-counter DUT signals
  logic        reset_n4;
  logic [5:0]  opcode_n4;
  logic        mem_ready_n4;
  logic        pcw_n4, pcwc_n4, irw_n4, rw_n4, mr_n4, mw_n4;
  logic        iord_n4, rd_n4, m2r_n4, asa_n4, wd_n4;
  logic [1:0]  asb_n4, aop_n4, pcs_n4;
  logic [3:0]  state_n4;
  logic [3:0]  retired_n4;
  logic        illegal_n4;

  mips_multicycle_ctrl #(.OPC_W(6), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .wd_sel(wd_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .retired(retired), .illegal_op(illegal_op)
  );

  mips_multicycle_ctrl #(.OPC_W(6), .CNT_W(4)) dut_n4 (
    .clk(clk), .reset(reset_n4), .opcode(opcode_n4), .mem_ready(mem_ready_n4),
    .pc_write(pcw_n4), .pc_write_cond(pcwc_n4), .ir_write(irw_n4),
    .reg_write(rw_n4), .mem_read(mr_n4), .mem_write(mw_n4),
    .iord(iord_n4), .reg_dst(rd_n4), .mem_to_reg(m2r_n4),
    .alu_src_a(asa_n4), .wd_sel(wd_n4), .alu_src_b(asb_n4),
    .alu_op(aop_n4), .pc_source(pcs_n4), .state(state_n4),
    .retired(retired_n4), .illegal_op(illegal_n4)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected control bundle, packed in a fixed field order
  typedef struct packed {
    logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
    logic       iord, reg_dst, mem_to_reg, alu_src_a, wd_sel;
    logic [1:0] alu_src_b, alu_op, pc_source;
  } ctrl_t;

  typedef struct {
    logic [5:0] opc;
    logic       mr;
    int         st;
    int         ret;
  } vec_t;

  vec_t vecs[$];
  int   vec_done = 0;

  // Per-instruction model trace
  int mtrace[5];
  int mlen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] opc, input logic mr, input logic rst);
    opcode    = opc;
    mem_ready = mr;
    reset     = rst;
  endtask

  task automatic do_reset();
    applyStimulus(6'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic ctrl_t act_ctrl();
    ctrl_t c;
    c = '{pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
          iord, reg_dst, mem_to_reg, alu_src_a, wd_sel, alu_src_b, alu_op, pc_source};
    return c;
  endfunction

  // Expected strobes per state, straight from the state table
  function automatic ctrl_t exp_ctrl(input int st, input logic mr, input logic rst);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: c.reg_write = 1;
      12: begin c.reg_write = 1; c.wd_sel = 1; end
      default: ;
    endcase
    if (rst) begin
      c.pc_write = 0; c.pc_write_cond = 0; c.ir_write = 0; c.reg_write = 0; c.mem_write = 0;
    end
    return c;
  endfunction

  // State trace each opcode walks through with mem_ready high
  task automatic load_trace(input logic [5:0] opc);
    mtrace = '{0, 1, 0, 0, 0};
    case (opc)
      6'h00: begin mtrace = '{0, 1, 6, 7, 0};  mlen = 4; end
      6'h23: begin mtrace = '{0, 1, 2, 3, 4};  mlen = 5; end
      6'h2B: begin mtrace = '{0, 1, 2, 5, 0};  mlen = 4; end
      6'h04: begin mtrace = '{0, 1, 8, 0, 0};  mlen = 3; end
      6'h02: begin mtrace = '{0, 1, 9, 0, 0};  mlen = 3; end
      6'h08: begin mtrace = '{0, 1, 10, 11, 0}; mlen = 4; end
      6'h0F: begin mtrace = '{0, 1, 12, 0, 0}; mlen = 3; end
      default: mlen = 2;
    endcase
  endtask

  function automatic bit is_wait_state(input int st);
    return (st == 0) || (st == 3) || (st == 5);
  endfunction

  task automatic add_inst(input logic [5:0] opc, input int n,
                          input int s0, input int s1, input int s2, input int s3, input int s4);
    int   s[5];
    vec_t v;
    s = '{s0, s1, s2, s3, s4};
    for (int i = 0; i < n; i++) begin
      v.opc = opc; v.mr = 1'b1; v.st = s[i]; v.ret = vec_done;
      vecs.push_back(v);
    end
    vec_done++;
  endtask

  function automatic logic [5:0] pick_opcode();
    logic [5:0] legal[7];
    logic [5:0] bad[3];
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0F};
    bad   = '{6'h3F, 6'h01, 6'h30};
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    if ($urandom_range(7) == 0) return bad[$urandom_range(2)];
`endif
    return legal[$urandom_range(6)];
  endfunction

  initial begin
    int irw_cnt, rw_cnt, rw_bad;
    int k, exp_ret;
    logic mr;
    logic [5:0] cur_op;

    reset_n4 = 1'b1; opcode_n4 = 6'h0F; mem_ready_n4 = 1'b1;

    // Vector table: back-to-back R, lw, sw, beq, j, addi, lui
    add_inst(6'h00, 4, 0, 1, 6, 7, 0);
    add_inst(6'h23, 5, 0, 1, 2, 3, 4);
    add_inst(6'h2B, 4, 0, 1, 2, 5, 0);
    add_inst(6'h04, 3, 0, 1, 8, 0, 0);
    add_inst(6'h02, 3, 0, 1, 9, 0, 0);
    add_inst(6'h08, 4, 0, 1, 10, 11, 0);
    add_inst(6'h0F, 3, 0, 1, 12, 0, 0);

    // Reset: write strobes must be held low even with mem_ready high
    applyStimulus(6'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_retired", retired, 32'd0);
    checkOutput("reset_illegal", 32'(illegal_op), 32'd0);
    checkOutput("reset_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(0, 1'b1, 1'b1)));
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].opc, vecs[i].mr, 1'b0);
      @(negedge clk);
      checkOutput("seq_state", 32'(state), 32'(vecs[i].st));
      checkOutput("seq_retired", retired, 32'(vecs[i].ret));
      checkOutput("seq_wd_sel", 32'(wd_sel), 32'(vecs[i].st == 12));
      if (vecs[i].st == 12) checkOutput("lui_mem_to_reg", 32'(mem_to_reg), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("seq_final_retired", retired, 32'd7);
    checkOutput("seq_final_state", 32'(state), 32'd0);

    // lw with 3 FETCH stalls and 2 MEM_READ stalls: 10 cycles
    do_reset();
    irw_cnt = 0; rw_cnt = 0; rw_bad = 0;
    for (int c = 0; c < 10; c++) begin
      mr = !((c < 3) || (c == 6) || (c == 7));
      applyStimulus(6'h23, mr, 1'b0);
      @(negedge clk);
      if (ir_write) irw_cnt++;
      if (reg_write) begin
        rw_cnt++;
        if (state != 4'd4) rw_bad++;
      end
      if (c == 9) checkOutput("lw_stall_last_state", 32'(state), 32'd4);
      @(posedge clk); #1;
    end
    applyStimulus(6'h23, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lw_stall_end_state", 32'(state), 32'd0);
    checkOutput("lw_stall_retired", retired, 32'd1);
    checkOutput("lw_stall_ir_pulses", 32'(irw_cnt), 32'd1);
    checkOutput("lw_stall_rw_pulses", 32'(rw_cnt), 32'd1);
    checkOutput("lw_stall_rw_outside_wb", 32'(rw_bad), 32'd0);
    @(posedge clk); #1;

    // Illegal opcode 0x3F
    do_reset();
    applyStimulus(6'h3F, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ill_fetch", 32'(state), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ill_decode", 32'(state), 32'd1);
    @(posedge clk); #1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("trap_state", 32'(state), 32'd13);
      checkOutput("trap_illegal", 32'(illegal_op), 32'd1);
      checkOutput("trap_strobes", 32'({pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read}), 32'd0);
      checkOutput("trap_retired", retired, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("trap_reset_state", 32'(state), 32'd0);
    checkOutput("trap_reset_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk); #1;
`else
    @(negedge clk);
    checkOutput("nop_state", 32'(state), 32'd0);
    checkOutput("nop_retired", retired, 32'd1);
    checkOutput("nop_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk); #1;
`endif

    // Reset while sw is stalled in MEM_WRITE
    do_reset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(6'h2B, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    applyStimulus(6'h2B, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sw_hold_state", 32'(state), 32'd5);
    checkOutput("sw_hold_mem_write", 32'(mem_write), 32'd1);
    @(posedge clk); #1;
    applyStimulus(6'h2B, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("sw_reset_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    applyStimulus(6'h2B, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sw_reset_next_state", 32'(state), 32'd0);
    checkOutput("sw_reset_retired", retired, 32'd0);
    @(posedge clk); #1;

    // Randomized instruction stream with random memory stalls
    do_reset();
    exp_ret = 0;
    cur_op  = pick_opcode();
    load_trace(cur_op);
    k = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      mr = ($urandom_range(3) != 0);
      applyStimulus(cur_op, mr, 1'b0);
      @(negedge clk);
      checkOutput("rnd_state", 32'(state), 32'(mtrace[k]));
      checkOutput("rnd_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(mtrace[k], mr, 1'b0)));
      checkOutput("rnd_retired", retired, 32'(exp_ret));
      checkOutput("rnd_illegal", 32'(illegal_op), 32'd0);
      @(posedge clk); #1;
      if (!(is_wait_state(mtrace[k]) && !mr)) begin
        k++;
        if (k == mlen) begin
          exp_ret++;
          cur_op = pick_opcode();
          load_trace(cur_op);
          k = 0;
        end
      end
    end

    // Counter wrap on a 4-bit instance: 15 lui, then one more wraps to 0
    reset_n4 = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("wrap_before", 32'(retired_n4), 32'd15);
    checkOutput("wrap_before_state", 32'(state_n4), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("wrap_after", 32'(retired_n4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
